memoria_principal_resp: RTL

- Main-memory responder at the far end of the L2 miss/write-back path in the hierarchy. It serves read and write requests that L2 initiates.
- Valid/ready request channel and valid/ready read-response channel.
- Fixed-latency reads.
- Writes are posted into a small write buffer, which drains to the storage array when idle. Reads forward from the buffer.

---
 rtl/mem_hier_pkg.sv | 10 +
 rtl/buffer_escrita_mp.sv | 49 ++++
 rtl/memoria_principal_resp.sv | 91 +++++++++
 3 files changed

// File: rtl/mem_hier_pkg.sv
// mem_hier_pkg: widths, FSM states and write-buffer entry shared across the memory hierarchy
package mem_hier_pkg;
    localparam int ADDR_WIDTH = 6;
    localparam int DATA_WIDTH = 16;
    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_RESP} mp_state_t;
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/buffer_escrita_mp.sv
// buffer_escrita_mp: posted-write FIFO with newest-match combinational lookup
module buffer_escrita_mp import mem_hier_pkg::*; #(
    parameter int DEPTH = 2,
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  wb_entry_t             push_entry,
    input  logic                  pop,
    output wb_entry_t             head_entry,
    output logic [CW-1:0]         count,
    input  logic [ADDR_WIDTH-1:0] lookup_addr,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] hit_data
);
    wb_entry_t q [DEPTH];
    logic [PW-1:0] head, tail;
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    assign head_entry = q[head];
    // walk oldest to newest so the last match seen is the newest
    always_comb begin
        hit = 1'b0;
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(count) && q[PW'((int'(head) + i) % DEPTH)].addr == lookup_addr) begin
                hit = 1'b1;
                hit_data = q[PW'((int'(head) + i) % DEPTH)].data;
            end
        end
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            head <= '0;
            tail <= '0;
            count <= '0;
        end else begin
            if (push) tail <= wrap_inc(tail);
            if (pop) head <= wrap_inc(head);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clock) begin
        if (push) q[tail] <= push_entry;
    end
endmodule

// File: rtl/memoria_principal_resp.sv
// memoria_principal_resp: fixed-latency main-memory responder with posted write buffer
module memoria_principal_resp import mem_hier_pkg::*; #(
    parameter int ADDR_WIDTH = mem_hier_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = mem_hier_pkg::DATA_WIDTH,
    parameter int LATENCY = 3,
    parameter int WB_DEPTH = 2,
    localparam int CW = $clog2(WB_DEPTH + 1),
    localparam int LW = LATENCY > 1 ? $clog2(LATENCY) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    input  logic                  resp_ready,
    output logic [CW-1:0]         wb_count,
    output logic                  busy
);
    mp_state_t state, state_n;
    logic [LW-1:0] cnt, cnt_n;
    logic [DATA_WIDTH-1:0] cap, rd_value, hit_data;
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    // unwritten words read back as their own address; 2-state so it starts all-zero
    bit [2**ADDR_WIDTH-1:0] written;
    wb_entry_t push_entry, head_entry;
    logic hit, accept, wr, rd, drain;
    assign req_ready = state == IDLE && wb_count < CW'(WB_DEPTH);
    assign accept = req_valid && req_ready;
    assign wr = accept && req_write;
    assign rd = accept && !req_write;
    assign drain = state == IDLE && !accept && wb_count != '0;
    assign busy = state != IDLE || wb_count != '0;
    assign push_entry = '{addr: req_addr, data: req_wdata};
    assign rd_value = hit ? hit_data : written[req_addr] ? mem[req_addr] : DATA_WIDTH'(req_addr);
    buffer_escrita_mp #(.DEPTH(WB_DEPTH)) u_wb (
        .clock(clock),
        .reset(reset),
        .push(wr),
        .push_entry(push_entry),
        .pop(drain),
        .head_entry(head_entry),
        .count(wb_count),
        .lookup_addr(req_addr),
        .hit(hit),
        .hit_data(hit_data)
    );
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        case (state)
            IDLE: if (rd) begin
                state_n = LATENCY == 1 ? RD_RESP : RD_WAIT;
                cnt_n = LW'(LATENCY - 1);
            end
            RD_WAIT: begin
                state_n = cnt == '0 ? RD_RESP : RD_WAIT;
                cnt_n = cnt == '0 ? cnt : cnt - 1'b1;
            end
            RD_RESP: state_n = resp_ready ? IDLE : RD_RESP;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            cnt <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            if (state_n == RD_RESP && state != RD_RESP) begin
                resp_valid <= 1'b1;
                resp_rdata <= state == IDLE ? rd_value : cap;
            end else if (state == RD_RESP && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end
    always_ff @(posedge clock) begin
        if (rd) cap <= rd_value;
        if (reset && drain) begin
            mem[head_entry.addr] <= head_entry.data;
            written[head_entry.addr] <= 1'b1;
        end
    end
endmodule
